mem_wb_pipe: RTL and testbench

Parametrised MEM→WB pipeline stage with valid/ready flow control, a one-entry skid buffer and a synchronous flush. It carries the GPR write, HI/LO write and destination fields from the memory stage to write-back. Unlike the combinational pass-through stage, it registers every field, provides back-pressure toward MEM, and squashes in-flight results on flush. It sits between `mem` and `regfile`/`hilo_reg` and replaces the unflow-controlled MEM/WB stage.

---
 rtl/mem_wb_pipe.sv | 107 ++++++++++
 tb/tb_mem_wb_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: registered MEM->WB stage with valid/ready flow control, one-entry skid buffer and flush
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit HILO_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              mem_whilo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic              wb_whilo
);
  localparam int CW = ADDR_W + 1 + DATA_W;
  localparam int HW = 2 * DATA_W + 1;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, nxt;
  logic rdy, accept, drain, ld_mi, ld_si, ld_ms;
  logic [CW-1:0] m_c, s_c, in_c;
  assign accept = in_valid & rdy;
  assign drain = out_valid & out_ready;
  assign in_ready = rdy;
  assign out_valid = state != EMPTY;
  assign in_c = {mem_wd, mem_wreg, mem_wdata};
  assign wb_wd = m_c[CW-1 -: ADDR_W];
  assign wb_wreg = m_c[DATA_W] & out_valid;
  assign wb_wdata = m_c[DATA_W-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      rdy <= 1'b1;
    end else begin
      state <= nxt;
      rdy <= nxt != TWO;
    end
  end
  always_comb begin
    nxt = state;
    ld_mi = 1'b0;
    ld_si = 1'b0;
    ld_ms = 1'b0;
    if (flush) nxt = EMPTY;
    else
      case (state)
        EMPTY: begin
          nxt = accept ? ONE : EMPTY;
          ld_mi = accept;
        end
        ONE: begin
          nxt = (accept & !drain) ? TWO : (!accept & drain) ? EMPTY : ONE;
          ld_mi = accept & drain;
          ld_si = accept & !drain;
        end
        TWO: begin
          nxt = drain ? ONE : TWO;
          ld_ms = drain;
        end
        default: nxt = EMPTY;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      m_c <= '0;
      s_c <= '0;
    end else begin
      if (ld_mi) m_c <= in_c;
      else if (ld_ms) m_c <= s_c;
      if (ld_si) s_c <= in_c;
    end
  end
  if (HILO_EN) begin : g_hilo
    logic [HW-1:0] m_h, s_h, in_h;
    assign in_h = {mem_hi, mem_lo, mem_whilo};
    assign wb_hi = m_h[HW-1 -: DATA_W];
    assign wb_lo = m_h[DATA_W:1];
    assign wb_whilo = m_h[0] & out_valid;
    always_ff @(posedge clk) begin
      if (rst | flush) begin
        m_h <= '0;
        s_h <= '0;
      end else begin
        if (ld_mi) m_h <= in_h;
        else if (ld_ms) m_h <= s_h;
        if (ld_si) s_h <= in_h;
      end
    end
  end else begin : g_nohilo
    logic unused_hilo;
    assign unused_hilo = ^{mem_hi, mem_lo, mem_whilo};
    assign wb_hi = '0;
    assign wb_lo = '0;
    assign wb_whilo = 1'b0;
  end
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed stimulus checked every cycle against a queue model of the stage
module tb_mem_wb_pipe;
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
  } beat_t;
  logic clk = 1'b0, rst, flush, in_valid, out_ready;
  logic [4:0] mem_wd;
  logic mem_wreg, mem_whilo;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic in_ready, out_valid, wb_wreg, wb_whilo;
  logic [4:0] wb_wd;
  logic [31:0] wb_wdata, wb_hi, wb_lo;
  logic in_ready2, out_valid2, wb_wreg2, wb_whilo2;
  logic [4:0] wb_wd2;
  logic [31:0] wb_wdata2, wb_hi2, wb_lo2;
  int cnt = 0, bad = 0;
  beat_t q[$];
  beat_t held, cur, exp_b;
  logic mrdy, started = 1'b0, acc, dr, exp_v;
  logic [4:0] seen[$];
  always #5 clk = ~clk;
  mem_wb_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .out_valid(out_valid), .out_ready(out_ready),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .wb_whilo(wb_whilo)
  );
  mem_wb_pipe #(.HILO_EN(0)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .out_valid(out_valid2), .out_ready(out_ready),
    .wb_wd(wb_wd2), .wb_wreg(wb_wreg2), .wb_wdata(wb_wdata2), .wb_hi(wb_hi2), .wb_lo(wb_lo2),
    .wb_whilo(wb_whilo2)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    cnt++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic send(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                      input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
    logic r;
    int n;
    in_valid = 1'b1;
    mem_wd = wd;
    mem_wreg = wreg;
    mem_wdata = wdata;
    mem_hi = hi;
    mem_lo = lo;
    mem_whilo = whilo;
    n = 0;
    do begin
      r = in_ready;
      tick();
      n++;
    end while (!r && n < 50);
    chk("accepted", r, 1);
  endtask
  always @(posedge clk) begin
    cur = '{mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo};
    if (!rst && out_valid && out_ready) seen.push_back(wb_wd);
    if (rst || flush) begin
      q.delete();
      held = '0;
      mrdy = 1'b1;
    end else begin
      acc = in_valid && mrdy;
      dr = q.size() > 0 && out_ready;
      if (dr) void'(q.pop_front());
      if (acc) q.push_back(cur);
      mrdy = q.size() < 2;
      if (q.size() > 0) held = q[0];
    end
    started = 1'b1;
  end
  always @(negedge clk) begin
    if (started) begin
      exp_v = q.size() > 0;
      exp_b = exp_v ? q[0] : held;
      chk("out_valid", out_valid, exp_v);
      chk("in_ready", in_ready, mrdy);
      chk("wb_wd", wb_wd, exp_b.wd);
      chk("wb_wreg", wb_wreg, exp_b.wreg & exp_v);
      chk("wb_wdata", wb_wdata, exp_b.wdata);
      chk("wb_hi", wb_hi, exp_b.hi);
      chk("wb_lo", wb_lo, exp_b.lo);
      chk("wb_whilo", wb_whilo, exp_b.whilo & exp_v);
      chk("out_valid2", out_valid2, exp_v);
      chk("in_ready2", in_ready2, mrdy);
      chk("wb_wd2", wb_wd2, exp_b.wd);
      chk("wb_wreg2", wb_wreg2, exp_b.wreg & exp_v);
      chk("wb_wdata2", wb_wdata2, exp_b.wdata);
      chk("wb_hi2", wb_hi2, 0);
      chk("wb_lo2", wb_lo2, 0);
      chk("wb_whilo2", wb_whilo2, 0);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, limit 100000 time units");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    mem_wd = 5'd5;
    mem_wreg = 1'b1;
    mem_wdata = 32'h55;
    mem_hi = 32'h1;
    mem_lo = 32'h2;
    mem_whilo = 1'b1;
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wb_wd", wb_wd, 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    chk("rst_wb_hi", wb_hi, 0);
    chk("rst_wb_wreg", wb_wreg, 0);
    rst = 1'b0;
    tick();
    chk("first_valid", out_valid, 1);
    chk("first_wd", wb_wd, 5);
    chk("first_wdata", wb_wdata, 32'h55);
    in_valid = 1'b0;
    tick();
    chk("first_drained", out_valid, 0);
    for (int i = 1; i <= 8; i++) begin
      send(5'(i), 1'b1, 32'h10 + 32'(i) - 32'd1, 32'h0, 32'h0, 1'b0);
      chk("stream_wd", wb_wd, i);
      chk("stream_wdata", wb_wdata, 32'h10 + i - 1);
      chk("stream_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    repeat (2) tick();
    seen.delete();
    fork
      begin
        for (int i = 1; i <= 4; i++) send(5'(i), 1'b1, 32'h20 + 32'(i), 32'h0, 32'h0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        tick();
        out_ready = 1'b0;
        tick();
        chk("skid_in_ready", in_ready, 0);
        chk("skid_wd", wb_wd, 1);
        repeat (2) tick();
        out_ready = 1'b1;
      end
    join
    repeat (4) tick();
    chk("order_count", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("order_wd", seen[i], i + 1);
    out_ready = 1'b0;
    send(5'd7, 1'b1, 32'h77, 32'h0, 32'h0, 1'b0);
    send(5'd8, 1'b1, 32'h88, 32'h0, 32'h0, 1'b0);
    chk("two_in_ready", in_ready, 0);
    flush = 1'b1;
    in_valid = 1'b1;
    mem_wd = 5'd9;
    mem_wreg = 1'b1;
    mem_wdata = 32'h99;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_wb_wreg", wb_wreg, 0);
    chk("flush_wb_wd", wb_wd, 0);
    chk("flush_wb_wdata", wb_wdata, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    seen.delete();
    repeat (3) tick();
    chk("flush_no_beat", seen.size(), 0);
    send(5'd3, 1'b0, 32'h0, 32'hDEADBEEF, 32'h12345678, 1'b1);
    chk("hilo_whilo", wb_whilo, 1);
    chk("hilo_hi", wb_hi, 32'hDEADBEEF);
    chk("hilo_lo", wb_lo, 32'h12345678);
    chk("hilo_wreg", wb_wreg, 0);
    chk("nohilo_hi", wb_hi2, 0);
    chk("nohilo_lo", wb_lo2, 0);
    chk("nohilo_whilo", wb_whilo2, 0);
    in_valid = 1'b0;
    mem_wreg = 1'b1;
    mem_whilo = 1'b1;
    repeat (4) begin
      tick();
      chk("gate_wreg", wb_wreg, 0);
      chk("gate_whilo", wb_whilo, 0);
    end
    out_ready = 1'b0;
    send(5'd11, 1'b1, 32'hB1, 32'h0, 32'h0, 1'b0);
    send(5'd12, 1'b1, 32'hC2, 32'h0, 32'h0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_wdata", wb_wdata, 0);
    out_ready = 1'b1;
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, bad);
    $finish;
  end
endmodule
